// File: rtl/pin_entry_ctrl.sv
// pin_entry_ctrl
//   Initiator side of the account authentication interface. It latches the
//   card's account number and collects keypad PIN digits into a binary value.
//   It then presents account number and PIN to the authenticator, samples the
//   verdict, and handles retries, lockout and the idle timeout in ENTRY.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   card_insert, card_acc_num  card-reader pulse and account number
//   digit_valid, digit         keypad digit strobe and BCD digit (10-15 ignored)
//   enter_key, clear_key,
//   cancel_key                 keypad strobes
//   auth_found, auth_index     authenticator verdict and account index
//   acc_num_out, pin_out,
//   auth_req                   request presented to the authenticator
//   granted, acc_index_out     session authenticated, latched account index
//   denied, locked, eject      failed-attempt pulse, lockout level, eject pulse
//   digit_count, tries_left    entry progress and remaining attempts
module pin_entry_ctrl #(
   parameter int PIN_DIGITS     = 4,
   parameter int MAX_TRIES      = 3,
   parameter int AUTH_WAIT      = 1,
   parameter int LOCK_CYCLES    = 16,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        card_insert,
   input  logic [3:0]  card_acc_num,
   input  logic        digit_valid,
   input  logic [3:0]  digit,
   input  logic        enter_key,
   input  logic        clear_key,
   input  logic        cancel_key,
   input  logic        auth_found,
   input  logic [3:0]  auth_index,
   output logic [3:0]  acc_num_out,
   output logic [15:0] pin_out,
   output logic        auth_req,
   output logic        granted,
   output logic [3:0]  acc_index_out,
   output logic        denied,
   output logic        locked,
   output logic        eject,
   output logic [2:0]  digit_count,
   output logic [1:0]  tries_left
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ENTRY   = 3'd1;
   localparam logic [2:0] S_SUBMIT  = 3'd2;
   localparam logic [2:0] S_GRANTED = 3'd3;
   localparam logic [2:0] S_LOCKED  = 3'd4;

   localparam int WW = (AUTH_WAIT      > 1) ? $clog2(AUTH_WAIT + 1)      : 1;
   localparam int LW = (LOCK_CYCLES    > 1) ? $clog2(LOCK_CYCLES + 1)    : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   localparam logic [2:0]    PIN_N     = 3'(PIN_DIGITS);
   localparam logic [1:0]    TRIES_N   = 2'(MAX_TRIES);
   localparam logic [WW-1:0] WAIT_LAST = WW'(AUTH_WAIT - 1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
   localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [2:0]    state_q,  state_d;
   logic [15:0]   acc_q,    acc_d;
   logic [2:0]    cnt_q,    cnt_d;
   logic [1:0]    tries_q,  tries_d;
   logic [3:0]    accn_q,   accn_d;
   logic [3:0]    idx_q,    idx_d;
   logic [WW-1:0] wait_q,   wait_d;
   logic [LW-1:0] lock_q,   lock_d;
   logic [TW-1:0] idle_q,   idle_d;
   logic          denied_q, denied_d;
   logic          eject_q,  eject_d;
   logic          any_key;

   // Any strobe, whether it acts or is ignored, counts as user activity.
   assign any_key = digit_valid | enter_key | clear_key | cancel_key;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      tries_d  = tries_q;
      accn_d   = accn_q;
      idx_d    = idx_q;
      wait_d   = wait_q;
      lock_d   = lock_q;
      idle_d   = idle_q;
      denied_d = 1'b0;
      eject_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (card_insert) begin
               accn_d  = card_acc_num;
               acc_d   = '0;
               cnt_d   = '0;
               tries_d = TRIES_N;
               idle_d  = '0;
               state_d = S_ENTRY;
            end
         end
         S_ENTRY: begin
            // Strict priority: only the highest-priority strobe acts.
            if (cancel_key) begin
               state_d = S_IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (enter_key) begin
               if (cnt_q == PIN_N) begin
                  state_d = S_SUBMIT;
                  wait_d  = '0;
               end
            end else if (clear_key) begin
               acc_d = '0;
               cnt_d = '0;
            end else if (digit_valid) begin
               if (digit <= 4'd9 && cnt_q < PIN_N) begin
                  acc_d = acc_q * 16'd10 + {12'd0, digit};
                  cnt_d = cnt_q + 3'd1;
               end
            end
            // A key in the same cycle pre-empts the timeout.
            if (any_key) begin
               idle_d = '0;
            end else if (idle_q == TOUT_LAST) begin
               eject_d = 1'b1;
               state_d = S_IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               idle_d = idle_q + TW'(1);
            end
         end
         S_SUBMIT: begin
            if (wait_q == WAIT_LAST) begin
               if (auth_found) begin
                  state_d = S_GRANTED;
                  idx_d   = auth_index;
               end else begin
                  acc_d = '0;
                  cnt_d = '0;
                  if (tries_q > 2'd1) begin
                     tries_d  = tries_q - 2'd1;
                     denied_d = 1'b1;
                     idle_d   = '0;
                     state_d  = S_ENTRY;
                  end else begin
                     tries_d = '0;
                     lock_d  = '0;
                     state_d = S_LOCKED;
                  end
               end
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         S_GRANTED: begin
            if (cancel_key) begin
               state_d = S_IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         S_LOCKED: begin
            if (lock_q == LOCK_LAST) begin
               eject_d = 1'b1;
               state_d = S_IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               lock_d = lock_q + LW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         tries_q  <= '0;
         accn_q   <= '0;
         idx_q    <= '0;
         wait_q   <= '0;
         lock_q   <= '0;
         idle_q   <= '0;
         denied_q <= 1'b0;
         eject_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         tries_q  <= tries_d;
         accn_q   <= accn_d;
         idx_q    <= idx_d;
         wait_q   <= wait_d;
         lock_q   <= lock_d;
         idle_q   <= idle_d;
         denied_q <= denied_d;
         eject_q  <= eject_d;
      end
   end

   // The PIN is only exposed while it is being submitted or has been accepted.
   assign pin_out       = (state_q == S_SUBMIT || state_q == S_GRANTED) ? acc_q : 16'd0;
   assign auth_req      = (state_q == S_SUBMIT);
   assign granted       = (state_q == S_GRANTED);
   assign locked        = (state_q == S_LOCKED);
   assign acc_num_out   = accn_q;
   assign acc_index_out = idx_q;
   assign denied        = denied_q;
   assign eject         = eject_q;
   assign digit_count   = cnt_q;
   assign tries_left    = tries_q;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// tb_pin_entry_ctrl
//   Directed bench for pin_entry_ctrl with default parameters: card/PIN flows,
//   retries and lockout, entry editing, key priority, idle timeout and
//   asynchronous reset during a submission.
module tb_pin_entry_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        card_insert, digit_valid, enter_key, clear_key, cancel_key, auth_found;
   logic [3:0]  card_acc_num, digit, auth_index;
   logic [3:0]  acc_num_out, acc_index_out;
   logic [15:0] pin_out;
   logic        auth_req, granted, denied, locked, eject;
   logic [2:0]  digit_count;
   logic [1:0]  tries_left;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pin_entry_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .card_insert(card_insert), .card_acc_num(card_acc_num),
      .digit_valid(digit_valid), .digit(digit),
      .enter_key(enter_key), .clear_key(clear_key), .cancel_key(cancel_key),
      .auth_found(auth_found), .auth_index(auth_index),
      .acc_num_out(acc_num_out), .pin_out(pin_out), .auth_req(auth_req),
      .granted(granted), .acc_index_out(acc_index_out), .denied(denied),
      .locked(locked), .eject(eject), .digit_count(digit_count),
      .tries_left(tries_left)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic insert(input logic [3:0] a);
      card_acc_num = a;
      card_insert  = 1'b1;
      tick();
      card_insert  = 1'b0;
   endtask

   task automatic key_digit(input logic [3:0] d);
      digit       = d;
      digit_valid = 1'b1;
      tick();
      digit_valid = 1'b0;
   endtask

   task automatic key_enter();
      enter_key = 1'b1;
      tick();
      enter_key = 1'b0;
   endtask

   task automatic key_clear();
      clear_key = 1'b1;
      tick();
      clear_key = 1'b0;
   endtask

   task automatic key_cancel();
      cancel_key = 1'b1;
      tick();
      cancel_key = 1'b0;
   endtask

   initial begin
      int lock_hi, ej, first;
      rst_n = 1'b0;
      card_insert = 0; digit_valid = 0; enter_key = 0; clear_key = 0; cancel_key = 0;
      auth_found = 0; card_acc_num = 0; digit = 0; auth_index = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_auth_req", auth_req, 0);
      check("rst_granted", granted, 0);
      check("rst_pin", pin_out, 0);
      check("rst_tries", tries_left, 0);
      check("rst_accnum", acc_num_out, 0);
      check("rst_flags", {locked, eject, denied, acc_index_out, digit_count}, 0);
      #3 rst_n = 1'b1;
      tick();

      // Correct PIN on first try
      insert(4'd3);
      check("t1_accnum", acc_num_out, 3);
      check("t1_tries", tries_left, 3);
      key_digit(4); key_digit(5); key_digit(6); key_digit(7);
      check("t1_count", digit_count, 4);
      auth_found = 1'b1; auth_index = 4'd3;
      key_enter();
      check("t1_req", auth_req, 1);
      check("t1_pin", pin_out, 4567);
      check("t1_granted_early", granted, 0);
      tick();
      check("t1_req_fall", auth_req, 0);
      check("t1_granted", granted, 1);
      check("t1_index", acc_index_out, 3);
      check("t1_pin_granted", pin_out, 4567);
      auth_found = 1'b0; auth_index = 4'd0;
      key_cancel();
      check("t1_cancel_granted", granted, 0);
      check("t1_cancel_pin", pin_out, 0);
      check("t1_cancel_index", acc_index_out, 0);

      // Retries then lockout
      insert(4'd5);
      for (int att = 1; att <= 3; att++) begin
         key_digit(1); key_digit(1); key_digit(1); key_digit(1);
         key_enter();
         check("t2_req", auth_req, 1);
         tick();
         if (att < 3) begin
            check("t2_denied", denied, 1);
            check("t2_tries", tries_left, 3 - att);
            check("t2_count_clr", digit_count, 0);
            tick();
            check("t2_denied_fall", denied, 0);
         end else begin
            check("t2_locked", locked, 1);
            check("t2_tries0", tries_left, 0);
            check("t2_no_denied", denied, 0);
         end
      end
      lock_hi = 1; ej = 0;
      cancel_key = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (k == 2) cancel_key = 1'b0;
         if (locked) lock_hi++;
         if (eject) ej++;
      end
      check("t2_lock_len", lock_hi, 16);
      check("t2_no_early_eject", ej, 0);
      tick();
      check("t2_unlocked", locked, 0);
      check("t2_eject", eject, 1);
      tick();
      check("t2_eject_fall", eject, 0);
      key_digit(3);
      check("t2_idle", digit_count, 0);

      // Entry editing
      insert(4'd2);
      key_digit(1); key_digit(2); key_digit(12); key_digit(3);
      check("t3_count3", digit_count, 3);
      key_enter();
      check("t3_short_enter", auth_req, 0);
      check("t3_count_keep", digit_count, 3);
      key_clear();
      check("t3_clear", digit_count, 0);
      key_digit(9); key_digit(0); key_digit(1); key_digit(2); key_digit(5);
      check("t3_count4", digit_count, 4);
      key_enter();
      check("t3_req", auth_req, 1);
      check("t3_pin", pin_out, 9012);
      tick();
      check("t3_denied", denied, 1);
      key_cancel();
      check("t3_cancel", digit_count, 0);

      // Simultaneous keys
      insert(4'd1);
      key_digit(1); key_digit(2); key_digit(3); key_digit(4);
      auth_found = 1'b1; auth_index = 4'd9;
      digit = 4'd8; digit_valid = 1'b1; enter_key = 1'b1;
      tick();
      digit_valid = 1'b0; enter_key = 1'b0;
      check("t4_req", auth_req, 1);
      check("t4_pin_no_digit", pin_out, 1234);
      check("t4_count", digit_count, 4);
      tick();
      check("t4_granted", granted, 1);
      check("t4_index", acc_index_out, 9);
      auth_found = 1'b0; auth_index = 4'd0;
      key_cancel();
      insert(4'd1);
      key_digit(1); key_digit(2); key_digit(3); key_digit(4);
      cancel_key = 1'b1; enter_key = 1'b1;
      tick();
      cancel_key = 1'b0; enter_key = 1'b0;
      check("t4_cancel_wins", auth_req, 0);
      check("t4_cancel_count", digit_count, 0);
      tick();
      check("t4_no_req_later", auth_req, 0);
      key_digit(7);
      check("t4_idle", digit_count, 0);

      // Idle timeout
      insert(4'd4);
      ej = 0; first = 0;
      for (int k = 1; k <= 1001; k++) begin
         tick();
         if (eject) begin
            ej++;
            if (first == 0) first = k;
         end
      end
      check("t5_eject_cycle", first, 1000);
      check("t5_eject_width", ej, 1);
      key_digit(2);
      check("t5_idle", digit_count, 0);

      insert(4'd4);
      ej = 0; first = 0;
      for (int k = 1; k <= 998; k++) begin
         tick();
         if (eject) begin
            ej++;
            if (first == 0) first = k;
         end
      end
      clear_key = 1'b1;
      tick();
      clear_key = 1'b0;
      if (eject) begin
         ej++;
         if (first == 0) first = 999;
      end
      for (int k = 1000; k <= 2001; k++) begin
         tick();
         if (eject) begin
            ej++;
            if (first == 0) first = k;
         end
      end
      check("t5_restart_cycle", first, 1999);
      check("t5_restart_width", ej, 1);

      // Async reset during SUBMIT
      insert(4'd7);
      key_digit(1); key_digit(2); key_digit(3); key_digit(4);
      key_enter();
      check("t6_req", auth_req, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_req_clr", auth_req, 0);
      check("t6_pin_clr", pin_out, 0);
      check("t6_acc_clr", acc_num_out, 0);
      check("t6_tries_clr", tries_left, 0);
      check("t6_count_clr", digit_count, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("t6_no_eject", eject, 0);
      key_digit(1); key_digit(2); key_digit(3); key_digit(4);
      key_enter();
      check("t6_need_card", auth_req, 0);
      check("t6_need_card_cnt", digit_count, 0);
      insert(4'd6);
      check("t6_new_card", acc_num_out, 6);
      check("t6_new_tries", tries_left, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
